// File: rtl/axi_dma_wr.sv
// AXI4-Stream to AXI4 write DMA (S2MM): streams cap_size bytes into memory as
// INCR bursts of up to BURST_LEN 32-byte beats, one burst in flight at a time.
module axi_dma_wr #(
  parameter int ADDR_WIDTH = 32,
  parameter int BURST_LEN  = 16
) (
  input  logic                  axi_aclk,
  input  logic                  axi_rst,
  input  logic [255:0]          s_axis_tdata,
  input  logic [31:0]           s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [ADDR_WIDTH-1:0] axi_awaddr,
  output logic [7:0]            axi_awlen,
  output logic [2:0]            axi_awsize,
  output logic [1:0]            axi_awburst,
  output logic [3:0]            axi_awcache,
  output logic [2:0]            axi_awprot,
  output logic                  axi_awvalid,
  input  logic                  axi_awready,
  output logic [255:0]          axi_wdata,
  output logic [31:0]           axi_wstrb,
  output logic                  axi_wlast,
  output logic                  axi_wvalid,
  input  logic                  axi_wready,
  input  logic [1:0]            axi_bresp,
  input  logic                  axi_bvalid,
  output logic                  axi_bready,
  input  logic                  write_start,
  input  logic                  write_reset,
  input  logic [ADDR_WIDTH-1:0] start_address,
  input  logic [ADDR_WIDTH-1:0] cap_size,
  output logic [ADDR_WIDTH-1:0] current_addr,
  output logic [7:0]            run_cycles,
  output logic                  wr_s2mm_err,
  output logic                  write_done
);

  typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_DONE, S_ERR} state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_BURST = ADDR_WIDTH'(BURST_LEN);

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [ADDR_WIDTH-1:0] r_beats_left;
  logic [7:0]            r_awlen;
  logic [7:0]            r_beat_cnt;
  logic [7:0]            r_run_cycles;
  logic                  r_pending;
  logic                  r_err;

  logic [ADDR_WIDTH-1:0] w_cap_beats;
  logic [ADDR_WIDTH-1:0] w_burst_beats;
  logic [ADDR_WIDTH-1:0] w_beats_after;
  logic                  w_w_fire;
  logic                  w_unused;

  function automatic logic [7:0] f_awlen(input logic [ADDR_WIDTH-1:0] beats);
    logic [ADDR_WIDTH-1:0] n;
    n = (beats > LP_BURST) ? LP_BURST : beats;
    return 8'(n - ADDR_WIDTH'(1));
  endfunction

  assign w_cap_beats   = {5'd0, cap_size[ADDR_WIDTH-1:5]};
  assign w_burst_beats = ADDR_WIDTH'(r_awlen) + ADDR_WIDTH'(1);
  assign w_beats_after = r_beats_left - w_burst_beats;
  assign w_unused      = ^{s_axis_tlast, start_address[4:0], cap_size[4:0]};

  assign axi_awsize   = 3'b101;
  assign axi_awburst  = 2'b01;
  assign axi_awcache  = 4'b0011;
  assign axi_awprot   = 3'b000;
  assign axi_awaddr   = r_cur_addr;
  assign axi_awlen    = r_awlen;
  assign axi_awvalid  = (r_state == S_AW);
  // Stream and W channel are wired straight through: no skid buffer.
  assign axi_wdata     = s_axis_tdata;
  assign axi_wstrb     = s_axis_tkeep;
  assign axi_wvalid    = (r_state == S_W) && s_axis_tvalid;
  assign s_axis_tready = (r_state == S_W) && axi_wready;
  assign axi_wlast     = (r_state == S_W) && (r_beat_cnt == r_awlen);
  assign w_w_fire      = axi_wvalid && axi_wready;
  assign axi_bready    = (r_state == S_B);
  assign write_done    = (r_state == S_DONE);
  assign current_addr  = r_cur_addr;
  assign run_cycles    = r_run_cycles;
  assign wr_s2mm_err   = r_err;

  always_ff @(posedge axi_aclk) begin
    if (axi_rst) begin
      r_state      <= S_IDLE;
      r_cur_addr   <= '0;
      r_awlen      <= '0;
      r_beat_cnt   <= '0;
      r_run_cycles <= '0;
      r_pending    <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_pending  <= 1'b0;
          r_beat_cnt <= '0;
          if (write_start && !write_reset) begin
            r_cur_addr   <= {start_address[ADDR_WIDTH-1:5], 5'd0};
            r_beats_left <= w_cap_beats;
            if (w_cap_beats == '0) begin
              r_state      <= S_DONE;
              r_run_cycles <= r_run_cycles + 8'd1;
            end else begin
              r_awlen <= f_awlen(w_cap_beats);
              r_state <= S_AW;
            end
          end
        end
        // An abort that coincides with the AW handshake must still carry the burst.
        S_AW: begin
          if (axi_awready) begin
            r_state <= S_W;
            if (write_reset) r_pending <= 1'b1;
          end else if (write_reset) begin
            r_state <= S_IDLE;
          end
        end
        S_W: begin
          if (write_reset) r_pending <= 1'b1;
          if (w_w_fire) begin
            if (axi_wlast) begin
              r_beat_cnt <= '0;
              r_state    <= S_B;
            end else begin
              r_beat_cnt <= r_beat_cnt + 8'd1;
            end
          end
        end
        S_B: begin
          if (write_reset) r_pending <= 1'b1;
          if (axi_bvalid) begin
            if (axi_bresp == 2'b00) begin
              r_cur_addr   <= r_cur_addr + (w_burst_beats << 5);
              r_beats_left <= w_beats_after;
              if (w_beats_after == '0) begin
                r_state      <= S_DONE;
                r_run_cycles <= r_run_cycles + 8'd1;
              end else if (r_pending || write_reset) begin
                r_state <= S_IDLE;
              end else begin
                r_awlen <= f_awlen(w_beats_after);
                r_state <= S_AW;
              end
            end else begin
              r_err   <= 1'b1;
              r_state <= S_ERR;
            end
          end
        end
        S_DONE: begin
          if (!write_start || write_reset) r_state <= S_IDLE;
        end
        S_ERR: begin
          if (write_reset) begin
            r_err   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_dma_wr.sv
// Bench for axi_dma_wr: randomized stream source and AXI slave, with burst
// layout, beat contents and counters predicted from the capture parameters.
module tb_axi_dma_wr;
  localparam int AW = 32;
  localparam int BL = 16;

  logic          clk = 1'b0;
  logic          axi_rst;
  logic [255:0]  s_axis_tdata;
  logic [31:0]   s_axis_tkeep;
  logic          s_axis_tlast;
  logic          s_axis_tvalid;
  logic          s_axis_tready;
  logic [AW-1:0] axi_awaddr;
  logic [7:0]    axi_awlen;
  logic [2:0]    axi_awsize;
  logic [1:0]    axi_awburst;
  logic [3:0]    axi_awcache;
  logic [2:0]    axi_awprot;
  logic          axi_awvalid;
  logic          axi_awready;
  logic [255:0]  axi_wdata;
  logic [31:0]   axi_wstrb;
  logic          axi_wlast;
  logic          axi_wvalid;
  logic          axi_wready;
  logic [1:0]    axi_bresp;
  logic          axi_bvalid;
  logic          axi_bready;
  logic          write_start;
  logic          write_reset;
  logic [AW-1:0] start_address;
  logic [AW-1:0] cap_size;
  logic [AW-1:0] current_addr;
  logic [7:0]    run_cycles;
  logic          wr_s2mm_err;
  logic          write_done;

  always #5 clk = ~clk;

  axi_dma_wr #(.ADDR_WIDTH(AW), .BURST_LEN(BL)) dut (
    .axi_aclk(clk), .axi_rst(axi_rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tlast(s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .axi_awaddr(axi_awaddr), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize),
    .axi_awburst(axi_awburst), .axi_awcache(axi_awcache), .axi_awprot(axi_awprot),
    .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast),
    .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .write_start(write_start), .write_reset(write_reset),
    .start_address(start_address), .cap_size(cap_size),
    .current_addr(current_addr), .run_cycles(run_cycles),
    .wr_s2mm_err(wr_s2mm_err), .write_done(write_done)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Stream source contents and what the slave saw
  logic [255:0] src_q[$];
  logic [31:0]  keep_q[$];
  int           src_idx = 0;
  logic [31:0]  aw_addr_q[$];
  logic [7:0]   aw_len_q[$];
  logic [255:0] wd_q[$];
  logic [31:0]  ws_q[$];
  logic         wl_q[$];
  int           wlast_cnt = 0;
  int           b_cnt = 0;
  int           idle_pct = 0;
  int           err_burst = -1;
  bit           drv_en = 0;
  bit           mon_en = 0;
  bit           s_fire = 0;
  bit           b_fire = 0;
  logic         prev_aw_wait = 1'b0;
  logic [31:0]  prev_awaddr = '0;
  logic [7:0]   prev_awlen = '0;
  logic [7:0]   exp_runs = '0;

  always @(posedge clk) begin
    #1;
    if (drv_en) begin
      if (!(s_axis_tvalid && !s_fire))
        s_axis_tvalid = (src_idx < src_q.size()) && ($urandom_range(99) >= idle_pct);
      if (src_idx < src_q.size()) begin
        s_axis_tdata = src_q[src_idx];
        s_axis_tkeep = keep_q[src_idx];
      end else begin
        s_axis_tdata = '0;
        s_axis_tkeep = '0;
      end
      axi_wready  = ($urandom_range(99) >= idle_pct);
      axi_awready = ($urandom_range(99) >= idle_pct);
      if (!(axi_bvalid && !b_fire)) begin
        axi_bvalid = (wlast_cnt > b_cnt) && ($urandom_range(99) >= idle_pct);
        axi_bresp  = (b_cnt == err_burst) ? 2'b10 : 2'b00;
      end
    end
    s_fire = 0;
    b_fire = 0;
  end

  // Handshakes seen here complete on the following rising edge.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("xfer_match", axi_wvalid & axi_wready, s_axis_tvalid & s_axis_tready);
      if (s_axis_tready) chk("wvalid_follows", axi_wvalid, s_axis_tvalid);
      if (!s_axis_tvalid) chk("wvalid_no_src", axi_wvalid, 1'b0);
      if (prev_aw_wait) begin
        chk("aw_hold_valid", axi_awvalid, 1'b1);
        chk("aw_hold_addr", axi_awaddr, prev_awaddr);
        chk("aw_hold_len", axi_awlen, prev_awlen);
      end
      prev_aw_wait = axi_awvalid && !axi_awready;
      prev_awaddr  = axi_awaddr;
      prev_awlen   = axi_awlen;
      if (axi_awvalid && axi_awready) begin
        chk("one_outstanding", b_cnt, aw_addr_q.size());
        aw_addr_q.push_back(axi_awaddr);
        aw_len_q.push_back(axi_awlen);
      end
      if (axi_wvalid && axi_wready) begin
        wd_q.push_back(axi_wdata);
        ws_q.push_back(axi_wstrb);
        wl_q.push_back(axi_wlast);
        if (axi_wlast) wlast_cnt++;
      end
      if (s_axis_tvalid && s_axis_tready) begin
        s_fire = 1;
        src_idx++;
      end
      if (axi_bvalid && axi_bready) begin
        b_fire = 1;
        b_cnt++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic setup(input int n);
    logic [255:0] d;
    src_q.delete(); keep_q.delete();
    aw_addr_q.delete(); aw_len_q.delete();
    wd_q.delete(); ws_q.delete(); wl_q.delete();
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 8; k++) d[k*32 +: 32] = $urandom;
      src_q.push_back(d);
      keep_q.push_back($urandom);
    end
    src_idx = 0; wlast_cnt = 0; b_cnt = 0;
  endtask

  // Expected layout: consecutive INCR bursts of min(BL, remaining) beats from base.
  task automatic check_bursts(input logic [31:0] st, input logic [31:0] cap, input int max_b);
    logic [31:0] addr;
    logic [31:0] e_addr[$];
    int e_len[$];
    int left, len, total, b;
    addr = st & 32'hFFFF_FFE0;
    left = int'(cap >> 5);
    total = 0;
    while (left > 0 && e_addr.size() < max_b) begin
      len = (left > BL) ? BL : left;
      e_addr.push_back(addr);
      e_len.push_back(len);
      addr = addr + 32'(len * 32);
      left -= len;
      total += len;
    end
    chk("aw_count", aw_addr_q.size(), e_addr.size());
    for (int i = 0; i < e_addr.size() && i < aw_addr_q.size(); i++) begin
      chk("aw_addr", aw_addr_q[i], e_addr[i]);
      chk("aw_len", aw_len_q[i], 8'(e_len[i] - 1));
    end
    chk("beat_count", wd_q.size(), total);
    b = 0;
    for (int i = 0; i < e_len.size(); i++) begin
      for (int j = 0; j < e_len[i]; j++) begin
        if (b < wd_q.size()) begin
          chk($sformatf("wdata[%0d]", b), wd_q[b], src_q[b]);
          chk($sformatf("wstrb[%0d]", b), ws_q[b], keep_q[b]);
          chk($sformatf("wlast[%0d]", b), wl_q[b], (j == e_len[i] - 1));
        end
        b++;
      end
    end
  endtask

  task automatic capture(input logic [31:0] st, input logic [31:0] cap, input int idle);
    int n;
    setup(int'(cap >> 5));
    idle_pct = idle;
    err_burst = -1;
    start_address = st;
    cap_size = cap;
    write_start = 1'b1;
    n = 0;
    while (!write_done && !wr_s2mm_err && n < 4000) begin
      tick();
      n++;
    end
    chk("capture_done", write_done, 1'b1);
    exp_runs++;
    check_bursts(st, cap, 1 << 30);
    chk("current_addr", current_addr, (st & 32'hFFFF_FFE0) + (cap & 32'hFFFF_FFE0));
    chk("run_cycles", run_cycles, exp_runs);
    chk("no_err", wr_s2mm_err, 1'b0);
    write_start = 1'b0;
    tick();
    tick();
    chk("done_clears", write_done, 1'b0);
  endtask

  initial begin
    int n;
    logic [31:0] st;
    axi_rst = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tlast = 1'b0;
    s_axis_tvalid = 1'b1; axi_wready = 1'b1; axi_awready = 1'b1;
    axi_bvalid = 1'b1; axi_bresp = 2'b00;
    write_start = 1'b1; write_reset = 1'b0;
    start_address = 32'h0000_1234; cap_size = 32'h400;
    repeat (3) tick();
    chk("rst_awvalid", axi_awvalid, 1'b0);
    chk("rst_wvalid", axi_wvalid, 1'b0);
    chk("rst_tready", s_axis_tready, 1'b0);
    chk("rst_bready", axi_bready, 1'b0);
    chk("rst_wlast", axi_wlast, 1'b0);
    chk("rst_done", write_done, 1'b0);
    chk("rst_runs", run_cycles, 8'd0);
    chk("rst_err", wr_s2mm_err, 1'b0);
    chk("rst_cur_addr", current_addr, 32'd0);
    chk("rst_awaddr", axi_awaddr, 32'd0);
    chk("rst_awlen", axi_awlen, 8'd0);
    chk("awsize", axi_awsize, 3'b101);
    chk("awburst", axi_awburst, 2'b01);
    chk("awcache", axi_awcache, 4'b0011);
    chk("awprot", axi_awprot, 3'b000);
    s_axis_tvalid = 1'b0; axi_wready = 1'b0; axi_awready = 1'b0; axi_bvalid = 1'b0;
    write_start = 1'b0;
    axi_rst = 1'b0;
    drv_en = 1;
    mon_en = 1;
    tick();

    capture(32'h0, 32'h400, 0);
    capture(32'h0, 32'h2A0, 0);
    for (int i = 0; i < 5; i++)
      capture(($urandom & 32'hFFFF_FE00) | 32'($urandom_range(31)), 32'($urandom_range(1, 32'h1400)), 30);

    // Error response on the second burst
    setup(64);
    idle_pct = 30;
    err_burst = 1;
    st = 32'h0000_4000;
    start_address = st; cap_size = 32'h800; write_start = 1'b1;
    n = 0;
    while (!wr_s2mm_err && n < 4000) begin tick(); n++; end
    chk("err_set", wr_s2mm_err, 1'b1);
    repeat (20) tick();
    chk("err_sticky", wr_s2mm_err, 1'b1);
    chk("err_no_done", write_done, 1'b0);
    chk("err_no_awvalid", axi_awvalid, 1'b0);
    check_bursts(st, 32'h800, 2);
    chk("err_cur_addr", current_addr, st + 32'h200);
    chk("err_runs", run_cycles, exp_runs);
    write_start = 1'b0;
    write_reset = 1'b1;
    tick();
    write_reset = 1'b0;
    chk("err_cleared", wr_s2mm_err, 1'b0);
    tick();
    chk("err_idle_awvalid", axi_awvalid, 1'b0);
    err_burst = -1;

    // Abort mid-burst: burst must finish, then no further AW
    setup(64);
    idle_pct = 0;
    st = 32'h0000_8000;
    start_address = st; cap_size = 32'h800; write_start = 1'b1;
    n = 0;
    while (wd_q.size() < 5 && n < 200) begin tick(); n++; end
    chk("abort_reached_beat5", wd_q.size() >= 5, 1'b1);
    write_reset = 1'b1;
    write_start = 1'b0;
    tick();
    write_reset = 1'b0;
    n = 0;
    while (b_cnt < 1 && n < 200) begin tick(); n++; end
    chk("abort_b_seen", b_cnt, 1);
    repeat (20) tick();
    check_bursts(st, 32'h800, 1);
    chk("abort_cur_addr", current_addr, st + 32'h200);
    chk("abort_runs", run_cycles, exp_runs);
    chk("abort_no_done", write_done, 1'b0);
    chk("abort_no_awvalid", axi_awvalid, 1'b0);

    // Sub-beat captures finish immediately; 256 more wrap the run counter
    setup(0);
    start_address = 32'h0000_0123; cap_size = 32'h10; write_start = 1'b1;
    tick();
    exp_runs++;
    chk("small_done", write_done, 1'b1);
    chk("small_runs", run_cycles, exp_runs);
    chk("small_cur_addr", current_addr, 32'h0000_0120);
    for (int i = 0; i < 256; i++) begin
      write_start = 1'b0;
      tick();
      chk("small_idle", write_done, 1'b0);
      write_start = 1'b1;
      tick();
      exp_runs++;
      chk("small_redo", write_done, 1'b1);
    end
    chk("runs_wrap", run_cycles, exp_runs);
    chk("small_no_aw", aw_addr_q.size(), 0);
    chk("small_no_beats", wd_q.size(), 0);
    write_start = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_dma_wr.md
Name: axi_dma_wr

Overview:
AXI4-Stream-to-AXI4 write DMA (S2MM): accepts 256-bit stream beats and writes cap_size bytes to memory starting at start_address, using INCR bursts of up to BURST_LEN beats. It is the write-side counterpart of axi_dma_rd. Its AXI master port connects to the same memory slave (axi_bram_ctrl_0 in simulation, DDR/HP port in hardware), so a buffer filled by this block is replayed by axi_dma_rd. One burst is outstanding at a time.

Parameters:
ADDR_WIDTH, 32, AXI address width and width of start_address, cap_size and current_addr.
BURST_LEN, 16, maximum beats per burst; legal values are 1..256.

Ports:
axi_aclk  input  1  single clock for all logic.
axi_rst  input  1  synchronous, active-high reset.
s_axis_tdata  input  256  stream data.
s_axis_tkeep  input  32  byte enables; driven straight onto axi_wstrb.
s_axis_tlast  input  1  ignored; length is set by cap_size.
s_axis_tvalid  input  1  stream valid.
s_axis_tready  output  1  stream ready.
axi_awaddr  output  ADDR_WIDTH  burst address.
axi_awlen  output  8  beats-1.
axi_awsize  output  3  constant 3'b101 (32 B).
axi_awburst  output  2  constant 2'b01 (INCR).
axi_awcache  output  4  constant 4'b0011.
axi_awprot  output  3  constant 3'b000.
axi_awvalid  output  1  AW valid.
axi_awready  input  1  AW ready.
axi_wdata  output  256  equals s_axis_tdata.
axi_wstrb  output  32  equals s_axis_tkeep.
axi_wlast  output  1  last beat of the burst.
axi_wvalid  output  1  W valid.
axi_wready  input  1  W ready.
axi_bresp  input  2  write response.
axi_bvalid  input  1  B valid.
axi_bready  output  1  B ready.
write_start  input  1  level; begins a capture when sampled high in IDLE.
write_reset  input  1  abort request; takes effect at a burst boundary.
start_address  input  ADDR_WIDTH  byte address, latched at start; bits [4:0] forced to 0.
cap_size  input  ADDR_WIDTH  bytes to write, latched at start; bits [4:0] ignored.
current_addr  output  ADDR_WIDTH  address of the next burst.
run_cycles  output  8  count of completed captures; wraps at 255->0.
wr_s2mm_err  output  1  sticky; set on a non-OKAY bresp.
write_done  output  1  high while in DONE.

Behaviour:
- Reset (axi_rst=1 at a clock edge): state=IDLE; all outputs are 0 except the constant AW fields; run_cycles=0; wr_s2mm_err=0; current_addr=0. Reset overrides everything, including mid-burst; the slave must be reset alongside.
- States: IDLE, AW, W, B, DONE, ERR.
- IDLE:
  - When write_start=1 and write_reset=0: latch base=start_address&~31 and beats_left=cap_size>>5; set current_addr=base.
  - If beats_left=0: go to DONE and increment run_cycles.
  - Otherwise go to AW.
- AW:
  - Drive awvalid=1, awaddr=current_addr, awlen=min(BURST_LEN,beats_left)-1.
  - Hold awaddr and awlen stable until awready. On awvalid&awready go to W.
  - awvalid must not drop before the handshake.
- W:
  - s_axis_tready=axi_wready; axi_wvalid=s_axis_tvalid; there is no buffering and zero added latency.
  - A beat counts on wvalid&wready.
  - wlast=1 when beat_cnt==awlen. After the wlast beat go to B.
  - s_axis_tready=0 in every state except W.
- B:
  - bready=1.
  - On bvalid with bresp==2'b00: current_addr += (awlen+1)*32 and beats_left -= awlen+1. Then:
    - if beats_left==0: go to DONE and increment run_cycles;
    - else if write_reset is pending: go to IDLE;
    - else go to AW.
  - On bvalid with bresp!=0: set wr_s2mm_err=1 and go to ERR.
- DONE: write_done=1; go to IDLE when write_start=0 or write_reset=1.
- ERR: hold the error; go to IDLE, clearing wr_s2mm_err, only on write_reset=1.
- write_reset:
  - In AW before the handshake it goes to IDLE immediately.
  - In W or B it is latched as pending, and the current burst finishes legally (the block waits for stream data).
  - The pending flag clears on entry to IDLE.
- 4 KB rule: callers keep base aligned to BURST_LEN*32 bytes so no burst crosses a 4 KB boundary. The block does not split bursts.
- Last burst: a short final burst has awlen=beats_left-1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.

Test Plan:
- BURST_LEN=16, start=0x0, cap_size=0x400, stream always valid, slave always ready -> 2 bursts at 0x000 and 0x200 with awlen=15; wlast on beats 16 and 32; run_cycles=1; write_done=1; read-back via axi_dma_rd matches an incrementing pattern.
- cap_size=0x2A0 (21 beats) -> bursts awlen=15 then awlen=4 at 0x200; current_addr ends at 0x2A0.
- Random s_axis_tvalid/axi_wready throttling, 30% idle -> no dropped or duplicated beats; AW signals stable until awready; wvalid follows tvalid.
- Slave returns bresp=2'b10 on the second burst -> wr_s2mm_err=1, no third AW; state stays ERR until a write_reset pulse returns it to IDLE and err to 0.
- write_reset asserted during beat 5 of the first burst with cap_size=0x800 -> first burst completes with 16 beats and B accepted, then IDLE with no second AW; run_cycles unchanged.
- cap_size=0x10 (less than one beat) with write_start held -> DONE next cycle, no AXI traffic, run_cycles increments once; after 256 such captures run_cycles wraps to 0.
